// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch stage with PC, 1-cycle imem
// interface, instruction FIFO, valid/ready output and redirect flush.
// Ports: clk, rst_b (async, active-high), imem_req/inst_addr/imem_rdata,
//   out_valid/out_ready/out_inst/out_pc, redirect_en/redirect_pc, halted.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_stall/perf_flush.
module mips_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    output logic            imem_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_epoch;
    logic            epoch;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fifo_inst [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic [CW:0]     occupancy;

    always_comb begin
        pop  = out_valid && out_ready && !redirect_en;
        push = inflight && (inflight_epoch == epoch) && !redirect_en;
        // A slot being popped this cycle is free by the time the new
        // request's response lands, so it is credited back here; this
        // is what sustains one instruction per cycle at depth 2.
        occupancy = {1'b0, count}
                  + {{CW{1'b0}}, inflight}
                  - {{CW{1'b0}}, pop};
    end

    assign inst_addr = pc;
    assign out_valid = (count != '0) && !halted;
    assign out_inst  = fifo_inst[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];
    assign imem_req  = !rst_b && !halted && !redirect_en
                     && (occupancy < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_en) begin
            // Epoch flip marks any response still owed as stale.
            pc       <= {redirect_pc[XLEN-1:2], 2'b00};
            epoch    <= ~epoch;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc             <= pc + XLEN'(4);
                inflight_pc    <= pc;
                inflight_epoch <= epoch;
            end
            if (push) begin
                fifo_inst[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]   <= inflight_pc;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (!out_valid && !halted) perf_stall <= perf_stall + 32'd1;
            if (redirect_en) perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: randomized scoreboard bench for mips_fetch_unit.
// Expected PC stream comes from a sequential-address model.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] inst_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halted;

    logic        imem_req2;
    logic [31:0] inst_addr2;
    logic [31:0] imem_rdata2;
    logic        out_valid2;
    logic [31:0] out_inst2;
    logic [31:0] out_pc2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
    logic [31:0] perf_fetched2, perf_stall2, perf_flush2;
`endif

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int redirects_since_rst = 0;
    int xfers_since_rst = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mips_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_b(rst),
        .imem_req(imem_req), .inst_addr(inst_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall),
        .perf_flush(perf_flush)
`endif
    );

    mips_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8),
                      .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst_b(rst),
        .imem_req(imem_req2), .inst_addr(inst_addr2),
        .imem_rdata(imem_rdata2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_inst(out_inst2), .out_pc(out_pc2),
        .redirect_en(1'b0), .redirect_pc(32'h0),
        .halted(1'b0)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched2), .perf_stall(perf_stall2),
        .perf_flush(perf_flush2)
`endif
    );

    // Synchronous memory: word = 0x1000 + address, else garbage.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? 32'h1000 + inst_addr  : 32'hDEAD_BEEF;
        imem_rdata2 <= imem_req2 ? 32'h1000 + inst_addr2 : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/empty expected data", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    task automatic redir(input logic [31:0] tgt);
        redirect_en = 1'b1;
        redirect_pc = tgt;
        refill({tgt[31:2], 2'b00});
        redirects_since_rst++;
        step();
        redirect_en = 1'b0;
    endtask

    // Monitor: pops the expected stream on every transfer.
    logic [31:0] prev_pc;
    bit          prev_hold;
    initial begin
        prev_hold = 0;
        prev_pc   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 0;
            end else begin
                if (halted) check("halt_valid", {31'b0, out_valid}, 32'd0);
                if (prev_hold && out_valid)
                    check("head_stable", out_pc, prev_pc);
                if (out_valid && out_ready && !redirect_en) begin
                    if (exp_q.size() == 0) begin
                        fail("scoreboard_empty");
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        check("out_pc", out_pc, e);
                        check("out_inst", out_inst, 32'h1000 + e);
                        xfers++;
                        xfers_since_rst++;
                    end
                end
                prev_hold = out_valid && !out_ready && !redirect_en;
                prev_pc   = out_pc;
            end
        end
    end

    // Second instance: PC wraps past the top of the address space.
    logic [31:0] exp2 [3];
    initial begin
        int k;
        exp2[0] = 32'hFFFF_FFF8;
        exp2[1] = 32'hFFFF_FFFC;
        exp2[2] = 32'h0000_0000;
        k = 0;
        @(negedge rst);
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clk);
            if (out_valid2) begin
                check("wrap_pc", out_pc2, exp2[k]);
                check("wrap_inst", out_inst2, 32'h1000 + exp2[k]);
                k++;
            end
        end
        if (k < 3) fail("wrap_timeout");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int since;
        rst = 1'b1;
        out_ready = 1'b1;
        halted = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        repeat (3) step();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_addr", inst_addr, 32'd0);
        check("rst_addr2", inst_addr2, 32'hFFFF_FFF8);

        refill(32'h0);
        rst = 1'b0;
        step();
        check("lat1_valid", {31'b0, out_valid}, 32'd0);
        check("pc_adv", inst_addr, 32'd4);
        step();
        check("lat2_valid", {31'b0, out_valid}, 32'd1);
        check("first_pc", out_pc, 32'd0);
        repeat (6) begin
            step();
            check("steady_valid", {31'b0, out_valid}, 32'd1);
        end

        out_ready = 1'b0;
        repeat (5) step();
        check("stall_req", {31'b0, imem_req}, 32'd0);
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        repeat (4) step();

        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        redir(32'h0000_0043);
        check("redir_valid0", {31'b0, out_valid}, 32'd0);
        step();
        check("redir_valid1", {31'b0, out_valid}, 32'd0);
        step();
        check("redir_valid2", {31'b0, out_valid}, 32'd1);
        check("redir_pc", out_pc, 32'h40);

        redir(32'hFFFF_FFF8);
        repeat (8) step();

        halted = 1'b1;
        #1;
        check("halt_req_now", {31'b0, imem_req}, 32'd0);
        step();
        check("halt_req", {31'b0, imem_req}, 32'd0);
        check("halt_out", {31'b0, out_valid}, 32'd0);
        repeat (3) step();
        halted = 1'b0;
        repeat (6) step();

        since = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(3) != 0);
            halted    = ($urandom_range(15) == 0);
            if ($urandom_range(19) == 0 || since >= 300) begin
                since = 0;
                redir($urandom);
            end else begin
                since++;
                step();
            end
        end

        out_ready = 1'b1;
        halted = 1'b0;
        rst = 1'b1;
        refill(32'h0);
        redirects_since_rst = 0;
        xfers_since_rst = 0;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check("mid_rst_resume", {31'b0, out_valid}, 32'd1);
        check("mid_rst_pc", out_pc, 32'd0);
        repeat (10) step();
        redir(32'h100);
        repeat (5) step();
        redir(32'h200);
        repeat (5) step();

`ifdef FETCH_PERF_CNT_EN
        check("perf_flush", perf_flush, 32'(redirects_since_rst));
        check("perf_fetched_ge", {31'b0, perf_fetched >= 32'(xfers_since_rst)},
              32'd1);
`endif
        check("progress", {31'b0, xfers > 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
